uart_rom_loader: RTL and testbench
==================================

// Module: uart_rom_loader
// PURPOSE
// - UART boot loader sitting directly upstream of the instruction ROM write port.
// - Receives a program image over a serial line and writes it word by word into ROM
//   (rom_wr_en_o/addr/data drive the ROM wr_en_i/wr_addr_i/wr_data_i).
// - Holds the core off (cpu_hold_o) while loading; reports done/error to the SoC.
// PARAMETERS
// - CLK_FREQ   50_000_000  core clock in Hz
// - BAUD       115_200     UART bit rate; DIV = CLK_FREQ/BAUD (integer, truncated)
// - BASE_ADDR  32'h0       byte address of the first ROM word written
// - MAX_WORDS  4096        largest accepted image, in words (equals ROM depth)
// PORTS
// - clk_i          in   1   core clock
// - rst_n_i        in   1   asynchronous active-low reset
// - boot_en_i      in   1   level: 1 = loader armed/active, 0 = abort/idle
// - uart_rx_i      in   1   serial input, idle high, 8N1, LSB first, asynchronous
// - rom_wr_en_o    out  1   one-cycle ROM write strobe
// - rom_wr_addr_o  out  32  ROM byte address, word aligned
// - rom_wr_data_o  out  32  ROM write data
// - cpu_hold_o     out  1   1 = keep core stalled/reset
// - busy_o         out  1   1 = in LEN/DATA/CSUM
// - done_o         out  1   1 = image loaded successfully (sticky until boot_en_i=0)
// - err_o          out  1   1 = load failed (sticky until boot_en_i=0)
// BEHAVIOUR
// - Reset: all outputs 0; FSM=IDLE; rx synchroniser flops = 1; counters 0.
// - RX: 2-FF sync on uart_rx_i. Falling edge while RX idle starts a frame; wait DIV/2
//   clocks, re-check low (high = glitch, discard); then sample 8 data bits and the stop
//   bit every DIV clocks. Byte valid 1 clk after stop sample. Stop=0 = framing error.
// - Protocol: 4-byte word count N (little-endian), then N*4 payload bytes; word =
//   {b3,b2,b1,b0}, i.e. first byte received is bits [7:0].
// - FSM: IDLE -> LEN when boot_en_i=1. LEN: collect 4 bytes; N==0 or N>MAX_WORDS -> ERR,
//   else DATA. DATA: after 4th byte of word k, next clk rom_wr_en_o=1 for exactly 1 clk,
//   addr = BASE_ADDR + 4*k, data = assembled word; addr/data hold until next write.
//   After word N-1 write -> CSUM (macro on) or DONE (macro off).
//   DONE/ERR: hold until boot_en_i=0, then IDLE.
// - Any framing error in LEN/DATA/CSUM -> ERR; partial word is never written.
// - boot_en_i=0 in any state -> IDLE next clk; no further writes; done_o/err_o/busy_o
//   clear; byte assembler and word counter cleared. An in-flight RX frame is finished
//   and discarded.
// - cpu_hold_o = 1 in LEN, DATA, CSUM, ERR; 0 in IDLE and DONE.
// - Bytes arriving in IDLE/DONE/ERR are received and discarded.
// - Word counter width clog2(MAX_WORDS+1); address arithmetic is 32-bit, no wrap check
//   beyond the MAX_WORDS limit.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined: after the last word, one checksum byte is expected;
//   value = sum mod 256 of all payload bytes (length bytes excluded).
//   Match -> DONE; mismatch -> ERR. Words already written are not rolled back.
// - Undefined: no CSUM state; DONE directly after the last write; trailing bytes ignored.
// TESTING (CLK_FREQ=50 MHz, BAUD=115200, DIV=434, BASE_ADDR=0)
// - Reset asserted mid-frame -> all outputs 0 immediately; after release FSM=IDLE,
//   no write until a full new sequence arrives.
// - boot_en_i=1; send 02 00 00 00 13 00 00 00 6F 00 00 00 [82 if macro] -> writes
//   (0x0, 0x00000013), (0x4, 0x0000006F), each strobe 1 clk; then done_o=1, cpu_hold_o=0.
// - Length 00 00 00 00 -> err_o=1, no write; length 01 10 00 00 (4097) -> err_o=1, no write.
// - Stop bit driven 0 on 6th byte -> err_o=1, cpu_hold_o=1, zero writes.
// - boot_en_i dropped after first word write, remaining bytes still sent -> exactly 1 write,
//   done_o=0, err_o=0.
// - Macro on: same image as load test with checksum 00 -> both writes occur, err_o=1,
//   done_o=0. Macro off: byte 00 ignored, done_o=1.
// - 1-clock low glitch on uart_rx_i in IDLE -> no byte, no state change.

Source files
------------

// File: rtl/uart_rom_loader_if.sv
// ROM write-port bundle driven by the UART boot loader (master) into the instruction ROM (slave).
interface uart_rom_loader_if;
    logic        rom_wr_en;
    logic [31:0] rom_wr_addr;
    logic [31:0] rom_wr_data;

    modport master (output rom_wr_en, output rom_wr_addr, output rom_wr_data);
    modport slave  (input  rom_wr_en, input  rom_wr_addr, input  rom_wr_data);
endinterface

// File: rtl/uart_rom_loader.sv
// UART boot loader: receives a length-prefixed program image (8N1) and writes it into ROM.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_rom_loader #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               boot_en_i,
    input  logic               uart_rx_i,
    uart_rom_loader_if.master  rom,
    output logic               cpu_hold_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);
    localparam int unsigned DIV    = CLK_FREQ / BAUD;
    localparam int unsigned HALF   = DIV / 2;
    localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]       rx_st_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             rx_valid_q, rx_ferr_q, rx_ign_q;

    logic [2:0]        st_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       word_q;
    logic [WCNT_W-1:0] word_cnt_q, n_words_q;
    logic              wr_en_q;
    logic [31:0]       wr_addr_q, wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic        byte_stb;
    logic [31:0] word_full;
    logic        len_bad;
    logic        last_word;

    // Bytes from frames that overlapped boot_en_i=0 are finished but never consumed.
    assign byte_stb  = rx_valid_q && !rx_ign_q;
    assign word_full = {rx_shift_q, word_q};
    assign len_bad   = (word_full == 32'd0) || (word_full > 32'(MAX_WORDS));
    assign last_word = ((word_cnt_q + 1'b1) == n_words_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ign_q   <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            if (!boot_en_i) rx_ign_q <= 1'b1;
            case (rx_st_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_st_q  <= RX_START;
                        rx_cnt_q <= '0;
                        rx_ign_q <= !boot_en_i;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_st_q    <= RX_IDLE;
                        rx_valid_q <= 1'b1;
                        rx_ferr_q  <= !rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q       <= ST_IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
            n_words_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (!boot_en_i) begin
                st_q       <= ST_IDLE;
                byte_cnt_q <= '0;
                word_q     <= '0;
                word_cnt_q <= '0;
                n_words_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end else begin
                case (st_q)
                    ST_IDLE: st_q <= ST_LEN;
                    ST_LEN: begin
                        if (byte_stb) begin
                            if (rx_ferr_q) begin
                                st_q <= ST_ERR;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                                word_q     <= word_full[31:8];
                                if (byte_cnt_q == 2'd3) begin
                                    n_words_q <= word_full[WCNT_W-1:0];
                                    st_q      <= len_bad ? ST_ERR : ST_DATA;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (byte_stb) begin
                            if (rx_ferr_q) begin
                                st_q <= ST_ERR;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                                word_q     <= word_full[31:8];
`ifdef LOADER_CHECKSUM_EN
                                sum_q      <= sum_q + rx_shift_q;
`endif
                                if (byte_cnt_q == 2'd3) begin
                                    wr_en_q    <= 1'b1;
                                    wr_addr_q  <= BASE_ADDR + (32'(word_cnt_q) << 2);
                                    wr_data_q  <= word_full;
                                    word_cnt_q <= word_cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                                    if (last_word) st_q <= ST_CSUM;
`else
                                    if (last_word) st_q <= ST_DONE;
`endif
                                end
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (byte_stb) begin
                            st_q <= (!rx_ferr_q && rx_shift_q == sum_q) ? ST_DONE : ST_ERR;
                        end
                    end
`endif
                    default: st_q <= st_q;
                endcase
            end
        end
    end

    assign rom.rom_wr_en   = wr_en_q;
    assign rom.rom_wr_addr = wr_addr_q;
    assign rom.rom_wr_data = wr_data_q;

    assign busy_o     = (st_q == ST_LEN) || (st_q == ST_DATA) || (st_q == ST_CSUM);
    assign cpu_hold_o = busy_o || (st_q == ST_ERR);
    assign done_o     = (st_q == ST_DONE);
    assign err_o      = (st_q == ST_ERR);
endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader with a shortened bit period (DIV=16).
module tb_uart_rom_loader;
    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 3_125_000;
    localparam int unsigned DIV      = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic boot_en = 1'b0;
    logic uart_rx = 1'b1;
    logic cpu_hold, busy, done, err;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int long_strobe = 0;
    logic prev_en = 1'b0;
    logic [31:0] log_addr [0:15];
    logic [31:0] log_data [0:15];
    logic [7:0] img [$];

    uart_rom_loader_if rom_if ();

    uart_rom_loader #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .BASE_ADDR (32'h0),
        .MAX_WORDS (4096)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .boot_en_i  (boot_en),
        .uart_rx_i  (uart_rx),
        .rom        (rom_if),
        .cpu_hold_o (cpu_hold),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_if.rom_wr_en) begin
            log_addr[wr_total % 16] = rom_if.rom_wr_addr;
            log_data[wr_total % 16] = rom_if.rom_wr_data;
            wr_total++;
            if (prev_en) long_strobe++;
        end
        prev_en = rom_if.rom_wr_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_img();
        foreach (img[i]) send_byte(img[i], 1'b1);
    endtask

    task automatic enable();
        boot_en = 1'b0;
        repeat (3) @(negedge clk);
        boot_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(done || err) && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(done || err)) begin
            errors++;
            $display("FAIL %s_timeout: done=%0b err=%0b, required one of them set", name, done, err);
        end
    endtask

    task automatic set_image(input logic [7:0] csum);
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        img.push_back(csum);
`else
        if (csum != 8'h82) img.push_back(csum);
`endif
    endtask

    task automatic check_two_words(input string name, input int base);
        checks++;
        if (wr_total - base !== 2) begin
            errors++;
            $display("FAIL %s_wr_count: got %0d required 2", name, wr_total - base);
        end else begin
            checks++;
            if (log_addr[base % 16] !== 32'h0 || log_data[base % 16] !== 32'h13) begin
                errors++;
                $display("FAIL %s_word0: got %h/%h required 00000000/00000013", name,
                         log_addr[base % 16], log_data[base % 16]);
            end
            checks++;
            if (log_addr[(base + 1) % 16] !== 32'h4 || log_data[(base + 1) % 16] !== 32'h6F) begin
                errors++;
                $display("FAIL %s_word1: got %h/%h required 00000004/0000006f", name,
                         log_addr[(base + 1) % 16], log_data[(base + 1) % 16]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_hold, busy, done, err, rom_if.rom_wr_en} !== 5'b0
            || rom_if.rom_wr_addr !== 32'h0 || rom_if.rom_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: hold/busy/done/err/wr=%b addr=%h data=%h required all 0",
                     {cpu_hold, busy, done, err, rom_if.rom_wr_en},
                     rom_if.rom_wr_addr, rom_if.rom_wr_data);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_hold, busy, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: hold/busy/done/err=%b required 0000",
                     {cpu_hold, busy, done, err});
        end
    endtask

    task automatic test_load();
        int base;
        base = wr_total;
        enable();
        set_image(8'h82);
        send_img();
        wait_end("load");
        check_two_words("load", base);
        checks++;
        if (long_strobe !== 0) begin
            errors++;
            $display("FAIL load_strobe_width: got %0d multi-cycle strobes required 0", long_strobe);
        end
        checks++;
        if ({done, err, cpu_hold, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL load_flags: done/err/hold/busy=%b required 1000",
                     {done, err, cpu_hold, busy});
        end
        checks++;
        if (rom_if.rom_wr_addr !== 32'h4 || rom_if.rom_wr_data !== 32'h6F) begin
            errors++;
            $display("FAIL load_hold_bus: got %h/%h required 00000004/0000006f",
                     rom_if.rom_wr_addr, rom_if.rom_wr_data);
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        uart_rx = 1'b0;
        repeat (DIV + 5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (DIV) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, busy, done, err, rom_if.rom_wr_en} !== 5'b0
            || rom_if.rom_wr_addr !== 32'h0 || rom_if.rom_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL midframe_reset: flags=%b addr=%h data=%h required all 0",
                     {cpu_hold, busy, done, err, rom_if.rom_wr_en},
                     rom_if.rom_wr_addr, rom_if.rom_wr_data);
        end
        repeat (3 * DIV) @(negedge clk);
        rst_n = 1'b1;
        base = wr_total;
        repeat (12 * DIV) @(negedge clk);
        checks++;
        if (wr_total !== base || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_quiet: writes=%0d busy=%b done=%b required 0/1/0",
                     wr_total - base, busy, done);
        end
        set_image(8'h82);
        send_img();
        wait_end("midframe");
        check_two_words("midframe", base);
    endtask

    task automatic test_len_errors();
        logic [31:0] lens [2];
        int base;
        lens[0] = 32'h0000_0000;
        lens[1] = 32'h0000_1001;
        for (int k = 0; k < 2; k++) begin
            base = wr_total;
            enable();
            for (int i = 0; i < 4; i++) send_byte(lens[k][8*i +: 8], 1'b1);
            wait_end("len");
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL len_%0d_err: err/done/hold=%b%b%b required 101", k, err, done,
                         cpu_hold);
            end
            checks++;
            if (wr_total !== base) begin
                errors++;
                $display("FAIL len_%0d_writes: got %0d required 0", k, wr_total - base);
            end
        end
    endtask

    task automatic test_framing();
        int base;
        base = wr_total;
        enable();
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13};
        send_img();
        send_byte(8'h00, 1'b0);
        wait_end("framing");
        checks++;
        if (err !== 1'b1 || cpu_hold !== 1'b1 || wr_total !== base) begin
            errors++;
            $display("FAIL framing_err: err=%b hold=%b writes=%0d required 1/1/0", err, cpu_hold,
                     wr_total - base);
        end
        boot_en = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL framing_clear: err=%b hold=%b required 0/0", err, cpu_hold);
        end
    endtask

    task automatic test_abort();
        int base;
        base = wr_total;
        enable();
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_img();
        repeat (4) @(negedge clk);
        checks++;
        if (wr_total - base !== 1) begin
            errors++;
            $display("FAIL abort_first: got %0d writes required 1", wr_total - base);
        end
        boot_en = 1'b0;
        img = '{8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        send_img();
        repeat (4) @(negedge clk);
        checks++;
        if (wr_total - base !== 1 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: writes=%0d done=%b err=%b busy=%b required 1/0/0/0",
                     wr_total - base, done, err, busy);
        end
    endtask

    task automatic test_checksum();
        int base;
        base = wr_total;
        enable();
        set_image(8'h00);
        send_img();
        wait_end("csum");
        check_two_words("csum", base);
        checks++;
`ifdef LOADER_CHECKSUM_EN
        if (err !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad: err=%b done=%b required 1/0", err, done);
        end
`else
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL csum_ignored: done=%b err=%b required 1/0", done, err);
        end
`endif
    endtask

    task automatic test_glitch();
        int base;
        boot_en = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checks++;
        if ({busy, cpu_hold, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL glitch_idle: busy/hold/done/err=%b required 0000",
                     {busy, cpu_hold, done, err});
        end
        base = wr_total;
        boot_en = 1'b1;
        repeat (3) @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        set_image(8'h82);
        send_img();
        wait_end("glitch");
        check_two_words("glitch", base);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL glitch_done: done=%b required 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_reset_midframe();
        test_len_errors();
        test_framing();
        test_abort();
        test_checksum();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
